// File: rtl/mem_responder.sv
// mem_responder
//
// Memory-side responder for a single-outstanding memory interface. It holds
// a word-addressed RAM and completes each read or write a fixed number of
// clock edges after the request is captured, then signals completion with a
// one-cycle pulse on mem_ack. All outputs come straight from flops.
//
// Parameters:
//   DEPTH   - number of 32-bit words in the RAM
//   LATENCY - clock edges from request capture to mem_ack assertion (>= 1)
//   CNT_W   - width of the latency counter (derived, leave at default)
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   rst         - asynchronous active-low reset
//   mem_addr    - byte address of the request (bits [1:0] ignored)
//   mem_wr_data - write data, sampled together with mem_wr_req
//   mem_rd_req  - read request, level-sampled while idle
//   mem_wr_req  - write request, level-sampled while idle (wins over read)
//   mem_rd_data - read data, updated only by reads, held otherwise
//   mem_ack     - one-cycle completion pulse
//   mem_busy    - high while a transaction is in flight
module mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3,
    parameter int CNT_W   = $clog2(LATENCY + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_rd_req,
    input  logic        mem_wr_req,
    output logic [31:0] mem_rd_data,
    output logic        mem_ack,
    output logic        mem_busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [29:0]       idx_q;
    logic [31:0]       wdata_q;
    logic              is_wr_q;
    logic              ack_q;
    logic              busy_q;
    logic [31:0]       rd_data_q;

    logic [31:0]       ram [DEPTH];

    logic              in_range;
    logic [AW-1:0]     ram_idx;
    logic              access;
    logic              ram_we;
    logic              unused_byte_offset;

    // Sub-word address bits carry no meaning for a word-addressed RAM.
    assign unused_byte_offset = ^mem_addr[1:0];

    // Out-of-range indices still complete normally; they just never touch
    // the RAM, and the truncated index keeps the array access in bounds.
    assign in_range = ({2'b00, idx_q} < 32'(DEPTH));
    assign ram_idx  = idx_q[AW-1:0];
    assign access   = (state_q == WAIT) && (cnt_q == '0);
    assign ram_we   = access && is_wr_q && in_range;

    // RAM storage is deliberately outside the reset domain so its contents
    // survive reset. The write enable derives from state_q, which resets
    // asynchronously, so an abandoned write can never commit.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= wdata_q;
        end
    end

    // Control FSM. The counter is loaded with LATENCY-1 on capture; the
    // access happens on the edge after it reaches zero, which places the
    // ack exactly LATENCY edges after capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            is_wr_q   <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (mem_wr_req || mem_rd_req) begin
                        idx_q   <= mem_addr[31:2];
                        wdata_q <= mem_wr_data;
                        is_wr_q <= mem_wr_req;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        if (!is_wr_q) begin
                            rd_data_q <= in_range ? ram[ram_idx] : 32'h0;
                        end
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd_data = rd_data_q;
    assign mem_ack     = ack_q;
    assign mem_busy    = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//
// Bench for mem_responder. The main instance (LATENCY=3) is driven through
// a scoreboard: each accepted request pushes its expected read data and ack
// cycle, and a monitor pops and compares whenever mem_ack is seen. Two
// auxiliary instances (LATENCY=4 and LATENCY=1) share one stimulus stream
// to exercise a reset that lands in the middle of a write.
module tb_mem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdReq;
    logic        wrReq;
    logic [31:0] rdData;
    logic        ack;
    logic        busy;

    logic        aRst;
    logic [31:0] aAddr;
    logic [31:0] aWdata;
    logic        aRdReq;
    logic        aWrReq;
    logic [31:0] l4RdData;
    logic        l4Ack;
    logic        l4Busy;
    logic [31:0] l1RdData;
    logic        l1Ack;
    logic        l1Busy;

    mem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (addr),
        .mem_wr_data (wdata),
        .mem_rd_req  (rdReq),
        .mem_wr_req  (wrReq),
        .mem_rd_data (rdData),
        .mem_ack     (ack),
        .mem_busy    (busy)
    );

    mem_responder #(.DEPTH(1024), .LATENCY(4)) dutL4 (
        .clk         (clk),
        .rst         (aRst),
        .mem_addr    (aAddr),
        .mem_wr_data (aWdata),
        .mem_rd_req  (aRdReq),
        .mem_wr_req  (aWrReq),
        .mem_rd_data (l4RdData),
        .mem_ack     (l4Ack),
        .mem_busy    (l4Busy)
    );

    mem_responder #(.DEPTH(1024), .LATENCY(1)) dutL1 (
        .clk         (clk),
        .rst         (aRst),
        .mem_addr    (aAddr),
        .mem_wr_data (aWdata),
        .mem_rd_req  (aRdReq),
        .mem_wr_req  (aWrReq),
        .mem_rd_data (l1RdData),
        .mem_ack     (l1Ack),
        .mem_busy    (l1Busy)
    );

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
        int          ackCycle;
    } exp_t;

    exp_t sbQ[$];
    exp_t monE;

    // Single comparison point: every check steps the shared counters.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack of the main instance must match the oldest
    // outstanding expectation in both read data and arrival cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && ack === 1'b1) begin
            if (sbQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_ack: got ack at cycle %0d, expected none", cycle);
            end else begin
                monE = sbQ.pop_front();
                checkOutput({monE.name, "_data"}, rdData, monE.data);
                checkOutput({monE.name, "_cycle"}, 32'(cycle), 32'(monE.ackCycle));
            end
        end
    end

    // Waits for the main instance to be idle, presents one request for a
    // single edge and records what the ack must carry.
    task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] expData);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while ((busy || ack) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_idle_wait: got busy after %0d cycles, expected idle", name, guard);
        end
        rdReq = rd;
        wrReq = wr;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        e.name     = name;
        e.data     = expData;
        e.ackCycle = cycle + LAT;
        sbQ.push_back(e);
        rdReq = 1'b0;
        wrReq = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sbQ.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (sbQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d outstanding, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    initial begin
        exp_t e;
        rst    = 1'b0;
        aRst   = 1'b0;
        rdReq  = 1'b1;
        wrReq  = 1'b0;
        addr   = 32'h1000;
        wdata  = 32'h0;
        aRdReq = 1'b0;
        aWrReq = 1'b0;
        aAddr  = 32'h0;
        aWdata = 32'h0;

        // Reset held with a read request pending: outputs stay quiet.
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset_ack", {31'b0, ack}, 32'h0);
            checkOutput("reset_busy", {31'b0, busy}, 32'h0);
            checkOutput("reset_rd_data", rdData, 32'h0);
        end

        // Release: the still-asserted read is captured on the first edge.
        rst  = 1'b1;
        aRst = 1'b1;
        @(posedge clk);
        #1;
        e.name     = "rst_release_rd";
        e.data     = 32'h0;
        e.ackCycle = cycle + LAT;
        sbQ.push_back(e);
        rdReq = 1'b0;
        checkOutput("busy_after_capture", {31'b0, busy}, 32'h1);

        applyStimulus("wr_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
        applyStimulus("rd_10", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        drain();
        repeat (2) @(negedge clk);
        checkOutput("rd_hold", rdData, 32'hDEADBEEF);

        applyStimulus("wr_0", 1'b0, 1'b1, 32'h0, 32'h0000600D, 32'hDEADBEEF);
        applyStimulus("wr_20", 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 32'hDEADBEEF);

        // A write issued one edge after a read is ignored entirely.
        applyStimulus("rd_20", 1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5);
        wrReq = 1'b1;
        addr  = 32'h20;
        wdata = 32'h5;
        @(posedge clk);
        #1;
        wrReq = 1'b0;
        applyStimulus("rd_20_again", 1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5);

        // Both requests high: write wins, read data untouched at its ack.
        applyStimulus("both_4", 1'b1, 1'b1, 32'h4, 32'h1234, 32'hA5A5A5A5);
        applyStimulus("rd_4", 1'b1, 1'b0, 32'h4, 32'h0, 32'h1234);

        // Out of range: acked, write dropped, read returns zero, word 0 safe.
        applyStimulus("wr_oor", 1'b0, 1'b1, 32'h1000, 32'h7, 32'h1234);
        applyStimulus("rd_oor", 1'b1, 1'b0, 32'h1000, 32'h0, 32'h0);
        applyStimulus("rd_0", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0000600D);
        drain();

        // Auxiliary instances: establish a known value at word 2.
        @(negedge clk);
        aWrReq = 1'b1;
        aAddr  = 32'h8;
        aWdata = 32'h11;
        @(posedge clk);
        #1;
        aWrReq = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("l4_idle_before", {31'b0, l4Busy}, 32'h0);

        // Second write, then reset two edges later.
        @(negedge clk);
        aWrReq = 1'b1;
        aWdata = 32'h9;
        @(posedge clk);
        #1;
        aWrReq = 1'b0;
        checkOutput("l4_busy_n", {31'b0, l4Busy}, 32'h1);
        @(posedge clk);
        #1;
        checkOutput("l1_ack_n1", {31'b0, l1Ack}, 32'h1);
        checkOutput("l4_noack_n1", {31'b0, l4Ack}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("l4_noack_n2", {31'b0, l4Ack}, 32'h0);
        aRst = 1'b0;
        #1;
        checkOutput("l4_busy_rst", {31'b0, l4Busy}, 32'h0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("l4_noack_rst", {31'b0, l4Ack}, 32'h0);
        end
        aRst = 1'b1;

        // Read back: LATENCY=4 abandoned the write, LATENCY=1 committed it.
        @(negedge clk);
        aRdReq = 1'b1;
        aAddr  = 32'h8;
        @(posedge clk);
        #1;
        aRdReq = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("l4_rd_after_rst", l4RdData, 32'h11);
        checkOutput("l1_rd_after_rst", l1RdData, 32'h9);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
